// File: rtl/axil_uart_tx_if.sv
// AXI-lite slave channel bundle for the UART transmitter.
// Signal directions are named from the peripheral's point of view.
interface axil_uart_tx_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] araddr_i;
  logic              arvalid_i;
  logic              arready_o;
  logic [DATA_W-1:0] rdata_o;
  logic [1:0]        rresp_o;
  logic              rvalid_o;
  logic              rready_i;
  logic [ADDR_W-1:0] awaddr_i;
  logic              awvalid_i;
  logic              awready_o;
  logic [DATA_W-1:0] wdata_i;
  logic [STRB_W-1:0] wstrb_i;
  logic              wvalid_i;
  logic              wready_o;
  logic [1:0]        bresp_o;
  logic              bvalid_o;
  logic              bready_i;

  modport slave (
    input  araddr_i, arvalid_i, rready_i, awaddr_i, awvalid_i,
           wdata_i, wstrb_i, wvalid_i, bready_i,
    output arready_o, rdata_o, rresp_o, rvalid_o, awready_o, wready_o,
           bresp_o, bvalid_o
  );

  modport master (
    output araddr_i, arvalid_i, rready_i, awaddr_i, awvalid_i,
           wdata_i, wstrb_i, wvalid_i, bready_i,
    input  arready_o, rdata_o, rresp_o, rvalid_o, awready_o, wready_o,
           bresp_o, bvalid_o
  );
endinterface

// File: rtl/axil_uart_tx.sv
// AXI-lite console UART transmitter: TX FIFO drained by an 8N1 serializer
// with a programmable clocks-per-bit divisor; STATUS/CTRL readable.
module axil_uart_tx #(
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 64,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd868,
  parameter bit          SIM_PRINT   = 1
) (
  input  logic          clk,
  input  logic          rst,
  axil_uart_tx_if.slave s_axi,
  output logic          txd_o,
  output logic          irq_o
);
  localparam int STRB_W = DATA_W / 8;
  localparam int LANE_W = $clog2(STRB_W);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = AW + 1;

  typedef enum logic [2:0] {W_IDLE, W_WAIT_AW, W_WAIT_W, W_EXEC, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txstate_t;

  wstate_t           r_wstate, w_wstate_nxt;
  rstate_t           r_rstate, w_rstate_nxt;
  txstate_t          r_txstate, w_txstate_nxt;

  logic [3:0]        r_awaddr;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;
  logic [1:0]        r_bresp;
  logic [DATA_W-1:0] r_rdata;
  logic [15:0]       r_div;
  logic              r_ie;

  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;

  logic [7:0]        r_shift;
  logic [15:0]       r_baud_cnt;
  logic [15:0]       r_bit_div;
  logic [2:0]        r_bitidx;

  logic              w_aw_hs, w_w_hs, w_ar_hs;
  logic [16:0]       w_wword;
  logic [2:0]        w_wstrb_l;
  logic              w_wr_txdata, w_wr_ctrl, w_exec;
  logic [PTR_W-1:0]  w_count;
  logic              w_full, w_empty, w_busy, w_enq, w_deq;
  logic [31:0]       w_status, w_ctrl, w_rd_word;
  logic [15:0]       w_div_eff;
  logic              w_bit_end;
  logic              w_unused;

  assign w_unused = ^{s_axi.awaddr_i[ADDR_W-1:4], s_axi.araddr_i[ADDR_W-1:4]};

  assign w_aw_hs = s_axi.awvalid_i & s_axi.awready_o;
  assign w_w_hs  = s_axi.wvalid_i & s_axi.wready_o;
  assign w_ar_hs = s_axi.arvalid_i & s_axi.arready_o;

  // Lane-aligned view of the captured write: register bits sit at byte lane addr[LANE_W-1:0]
  assign w_wword     = 17'(r_wdata >> {r_awaddr[LANE_W-1:0], 3'b000});
  assign w_wstrb_l   = 3'(r_wstrb >> r_awaddr[LANE_W-1:0]);
  assign w_exec      = (r_wstate == W_EXEC);
  assign w_wr_txdata = w_exec && (r_awaddr == 4'h0);
  assign w_wr_ctrl   = w_exec && (r_awaddr == 4'h8);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_wstate <= W_IDLE;
    else      r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE: begin
        if (s_axi.awvalid_i && s_axi.wvalid_i) w_wstate_nxt = W_EXEC;
        else if (s_axi.wvalid_i)               w_wstate_nxt = W_WAIT_AW;
        else if (s_axi.awvalid_i)              w_wstate_nxt = W_WAIT_W;
      end
      W_WAIT_AW: if (s_axi.awvalid_i) w_wstate_nxt = W_EXEC;
      W_WAIT_W:  if (s_axi.wvalid_i)  w_wstate_nxt = W_EXEC;
      W_EXEC:    w_wstate_nxt = W_RESP;
      W_RESP:    if (s_axi.bready_i)  w_wstate_nxt = W_IDLE;
      default:   w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    s_axi.awready_o = (r_wstate == W_IDLE) || (r_wstate == W_WAIT_AW);
    s_axi.wready_o  = (r_wstate == W_IDLE) || (r_wstate == W_WAIT_W);
    s_axi.bvalid_o  = (r_wstate == W_RESP);
    s_axi.bresp_o   = r_bresp;
  end

  always_ff @(posedge clk) begin
    if (w_aw_hs) r_awaddr <= s_axi.awaddr_i[3:0];
    if (w_w_hs) begin
      r_wdata <= s_axi.wdata_i;
      r_wstrb <= s_axi.wstrb_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div   <= DEFAULT_DIV;
      r_ie    <= 1'b0;
      r_bresp <= 2'b00;
    end else if (w_exec) begin
      r_bresp <= (w_wr_txdata && w_wstrb_l[0] && w_full) ? 2'b10 : 2'b00;
      if (w_wr_ctrl && w_wstrb_l[0]) r_div[7:0]  <= w_wword[7:0];
      if (w_wr_ctrl && w_wstrb_l[1]) r_div[15:8] <= w_wword[15:8];
      if (w_wr_ctrl && w_wstrb_l[2]) r_ie        <= w_wword[16];
    end
  end

  // FIFO: one extra pointer bit distinguishes full from empty
  assign w_count = r_wptr - r_rptr;
  assign w_full  = (w_count == PTR_W'(FIFO_DEPTH));
  assign w_empty = (w_count == '0);
  assign w_enq   = w_wr_txdata && w_wstrb_l[0] && !w_full;
  assign w_deq   = (r_txstate == TX_IDLE) && !w_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + PTR_W'(1);
      if (w_deq) r_rptr <= r_rptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_wptr[AW-1:0]] <= w_wword[7:0];
  end

  assign w_busy   = (r_txstate != TX_IDLE);
  assign w_status = {16'h0, 8'(w_count), 5'h0, w_busy, w_empty, w_full};
  assign w_ctrl   = {15'h0, r_ie, r_div};
  assign irq_o    = w_empty & r_ie;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rstate <= R_IDLE;
    else      r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (s_axi.arvalid_i) w_rstate_nxt = R_RESP;
      R_RESP:  if (s_axi.rready_i)  w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi.arready_o = (r_rstate == R_IDLE);
    s_axi.rvalid_o  = (r_rstate == R_RESP);
    s_axi.rdata_o   = r_rdata;
    s_axi.rresp_o   = 2'b00;
  end

  always_comb begin
    w_rd_word = 32'h0;
    case (s_axi.araddr_i[3:0])
      4'h4:    w_rd_word = w_status;
      4'h8:    w_rd_word = w_ctrl;
      default: w_rd_word = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_rdata <= '0;
    else if (w_ar_hs) r_rdata <= DATA_W'(w_rd_word) << {s_axi.araddr_i[LANE_W-1:0], 3'b000};
  end

  // Serializer: the bit period is latched at each bit start so DIV changes land on a boundary
  assign w_div_eff = (r_div == 16'd0) ? 16'd1 : r_div;
  assign w_bit_end = (r_baud_cnt == r_bit_div - 16'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_txstate <= TX_IDLE;
    else      r_txstate <= w_txstate_nxt;
  end

  always_comb begin
    w_txstate_nxt = r_txstate;
    case (r_txstate)
      TX_IDLE:  if (!w_empty) w_txstate_nxt = TX_START;
      TX_START: if (w_bit_end) w_txstate_nxt = TX_DATA;
      TX_DATA:  if (w_bit_end && r_bitidx == 3'd7) w_txstate_nxt = TX_STOP;
      TX_STOP:  if (w_bit_end) w_txstate_nxt = TX_IDLE;
      default:  w_txstate_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    case (r_txstate)
      TX_START: txd_o = 1'b0;
      TX_DATA:  txd_o = r_shift[0];
      default:  txd_o = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_baud_cnt <= 16'd0;
      r_bit_div  <= 16'd1;
      r_bitidx   <= 3'd0;
    end else if (r_txstate == TX_IDLE) begin
      r_baud_cnt <= 16'd0;
      r_bit_div  <= w_div_eff;
      r_bitidx   <= 3'd0;
    end else if (w_bit_end) begin
      r_baud_cnt <= 16'd0;
      r_bit_div  <= w_div_eff;
      if (r_txstate == TX_DATA) r_bitidx <= r_bitidx + 3'd1;
    end else begin
      r_baud_cnt <= r_baud_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_deq)                                r_shift <= r_mem[r_rptr[AW-1:0]];
    else if (r_txstate == TX_DATA && w_bit_end) r_shift <= {1'b0, r_shift[7:1]};
  end

  generate
    if (SIM_PRINT) begin : g_echo
      always_ff @(posedge clk) begin
        if (w_deq) $write("%c", r_mem[r_rptr[AW-1:0]]);
      end
    end
  endgenerate
endmodule

// File: tb/tb_axil_uart_tx.sv
// Scoreboard bench for axil_uart_tx: B, R and serial-frame monitors check
// against queues of expected responses pushed by the stimulus process.
module tb_axil_uart_tx;
  localparam int          ADDR_W      = 32;
  localparam int          DATA_W      = 64;
  localparam int          FIFO_DEPTH  = 16;
  localparam logic [15:0] DEFAULT_DIV = 16'd868;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic txd, irq;

  int checks = 0;
  int errors = 0;
  int cur_div = 868;

  logic [1:0]  bq [$];
  logic [63:0] rq [$];
  logic [7:0]  tq [$];

  axil_uart_tx_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axil_uart_tx #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH),
    .DEFAULT_DIV(DEFAULT_DIV), .SIM_PRINT(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .s_axi(bus), .txd_o(txd), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no/unexpected event, required a matching event", name);
  endtask

  // B and R channel monitor
  initial begin
    forever begin
      @(negedge clk); #1;
      if (bus.bvalid_o && bus.bready_i) begin
        if (bq.size() == 0) fail_now("b_unexpected");
        else chk("bresp", 64'(bus.bresp_o), 64'(bq.pop_front()));
      end
      if (bus.rvalid_o && bus.rready_i) begin
        if (rq.size() == 0) fail_now("r_unexpected");
        else begin
          chk("rdata", bus.rdata_o, rq.pop_front());
          chk("rresp", 64'(bus.rresp_o), 64'h0);
        end
      end
    end
  end

  // Serial monitor: every cycle of a frame must carry the expected bit
  initial begin : uart_mon
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge clk); #1;
      if (rst && prev && !txd) begin
        logic [7:0] exp_b, got_b;
        bit ok, aborted;
        int n;
        ok = 1'b1; aborted = 1'b0; n = cur_div; got_b = 8'h00;
        if (tq.size() == 0) begin
          fail_now("uart_unexpected_frame");
          exp_b = 8'h00;
        end else exp_b = tq.pop_front();
        for (int b = 0; b < 10 && !aborted; b++) begin
          for (int c = 0; c < n && !aborted; c++) begin
            logic eb;
            if (b != 0 || c != 0) begin @(negedge clk); #1; end
            eb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp_b[b-1];
            if (!rst) aborted = 1'b1;
            else begin
              if (txd !== eb) ok = 1'b0;
              if (b >= 1 && b <= 8 && c == 0) got_b[b-1] = txd;
            end
          end
        end
        if (!aborted) chk("uart_frame", {55'h0, ok, got_b}, {55'h0, 1'b1, exp_b});
      end
      prev = txd;
    end
  end

  task automatic axi_write(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb,
                           input logic [1:0] exp, input int aw_dly, input int w_dly,
                           output int lat, output logic [2:0] irq_tr);
    bit aw_done, w_done;
    int cyc;
    aw_done = 1'b0; w_done = 1'b0; cyc = 0; lat = 0; irq_tr = 3'b000;
    bq.push_back(exp);
    bus.awaddr_i = addr; bus.wdata_i = data; bus.wstrb_i = strb;
    while (!(aw_done && w_done) && cyc < 50) begin
      if (w_done && !aw_done) chk("ready_in_wait_aw", {62'h0, bus.awready_o, bus.wready_o}, 64'h2);
      if (aw_done && !w_done) chk("ready_in_wait_w", {62'h0, bus.awready_o, bus.wready_o}, 64'h1);
      bus.awvalid_i = !aw_done && (cyc >= aw_dly);
      bus.wvalid_i  = !w_done && (cyc >= w_dly);
      if (bus.awvalid_i && bus.awready_o) aw_done = 1'b1;
      if (bus.wvalid_i && bus.wready_o)   w_done = 1'b1;
      @(negedge clk);
      cyc++;
    end
    bus.awvalid_i = 1'b0;
    bus.wvalid_i  = 1'b0;
    if (!(aw_done && w_done)) begin
      fail_now("aw_w_timeout");
      void'(bq.pop_back());
      return;
    end
    irq_tr[2] = irq;
    lat = 1;
    while (!bus.bvalid_o && lat < 50) begin @(negedge clk); lat++; end
    irq_tr[1] = irq;
    if (!bus.bvalid_o) begin
      fail_now("b_timeout");
      void'(bq.pop_back());
      return;
    end
    bus.bready_i = 1'b1;
    @(negedge clk);
    bus.bready_i = 1'b0;
    irq_tr[0] = irq;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [63:0] exp, input int hold);
    int cyc;
    cyc = 0;
    rq.push_back(exp);
    bus.araddr_i = addr; bus.arvalid_i = 1'b1;
    while (!bus.arready_o && cyc < 50) begin @(negedge clk); cyc++; end
    @(negedge clk);
    bus.arvalid_i = 1'b0;
    cyc = 0;
    while (!bus.rvalid_o && cyc < 50) begin @(negedge clk); cyc++; end
    if (!bus.rvalid_o) begin
      fail_now("r_timeout");
      void'(rq.pop_back());
      return;
    end
    for (int i = 0; i < hold; i++) begin
      chk("r_hold_valid", 64'(bus.rvalid_o), 64'h1);
      chk("r_hold_data", bus.rdata_o, exp);
      @(negedge clk);
    end
    bus.rready_i = 1'b1;
    @(negedge clk);
    bus.rready_i = 1'b0;
  endtask

  initial begin
    int lat;
    logic [2:0] irq_tr;
    bus.araddr_i = '0; bus.arvalid_i = 1'b0; bus.rready_i = 1'b0;
    bus.awaddr_i = '0; bus.awvalid_i = 1'b0; bus.wdata_i = '0;
    bus.wstrb_i = '0;  bus.wvalid_i = 1'b0;  bus.bready_i = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_txd", 64'(txd), 64'h1);
    chk("rst_irq", 64'(irq), 64'h0);
    chk("rst_bvalid", 64'(bus.bvalid_o), 64'h0);
    chk("rst_rvalid", 64'(bus.rvalid_o), 64'h0);
    chk("rst_rdata", bus.rdata_o, 64'h0);
    chk("rst_bresp", 64'(bus.bresp_o), 64'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_readies", {61'h0, bus.awready_o, bus.wready_o, bus.arready_o}, 64'h7);
    axi_read(32'h4, 64'h0000_0002_0000_0000, 0);
    axi_read(32'h8, 64'h0000_0000_0000_0364, 0);

    // 0x41 at DIV=2, AW and W together
    cur_div = 2;
    axi_write(32'h8, 64'h2, 8'h0F, 2'b00, 0, 0, lat, irq_tr);
    tq.push_back(8'h41);
    axi_write(32'h0, 64'h41, 8'h01, 2'b00, 0, 0, lat, irq_tr);
    chk("b_latency", 64'(lat), 64'h2);
    repeat (40) @(negedge clk);
    axi_read(32'h4, 64'h0000_0002_0000_0000, 0);

    // W before AW, then AW before W
    tq.push_back(8'h42);
    tq.push_back(8'h43);
    axi_write(32'h0, 64'h42, 8'h01, 2'b00, 1, 0, lat, irq_tr);
    axi_write(32'h0, 64'h43, 8'h01, 2'b00, 0, 1, lat, irq_tr);
    repeat (60) @(negedge clk);

    // CTRL write and held read, then interrupt behaviour
    cur_div = 3;
    axi_write(32'h8, 64'h0001_0003, 8'h0F, 2'b00, 0, 0, lat, irq_tr);
    axi_read(32'h8, 64'h0000_0000_0001_0003, 3);
    chk("irq_idle_ie", 64'(irq), 64'h1);
    tq.push_back(8'h44);
    axi_write(32'h0, 64'h44, 8'h01, 2'b00, 0, 0, lat, irq_tr);
    chk("irq_trace", 64'(irq_tr), 64'h5);
    repeat (50) @(negedge clk);
    chk("frames_done", 64'(tq.size()), 64'h0);

    // TXDATA with its lane strobe clear must not enqueue
    axi_write(32'h0, 64'h55, 8'h00, 2'b00, 0, 0, lat, irq_tr);
    axi_read(32'h4, 64'h0000_0002_0000_0000, 0);

    // Overfill the FIFO while the serializer crawls
    cur_div = 65535;
    axi_write(32'h8, 64'h0000_FFFF, 8'h0F, 2'b00, 0, 0, lat, irq_tr);
    tq.push_back(8'h50);
    for (int i = 0; i < FIFO_DEPTH + 2; i++)
      axi_write(32'h0, 64'(8'h50 + i), 8'h01, (i == FIFO_DEPTH + 1) ? 2'b10 : 2'b00, 0, 0, lat, irq_tr);
    axi_read(32'h4, 64'h0000_1005_0000_0000, 0);
    chk("irq_ie_off", 64'(irq), 64'h0);
    rst = 1'b0;
    @(negedge clk);
    tq.delete();
    rst = 1'b1;
    @(negedge clk);

    // Reset in the middle of the data bits with bytes still queued
    cur_div = 4;
    axi_write(32'h8, 64'h4, 8'h0F, 2'b00, 0, 0, lat, irq_tr);
    repeat (4) begin
      tq.push_back(8'h00);
      axi_write(32'h0, 64'h0, 8'h01, 2'b00, 0, 0, lat, irq_tr);
    end
    repeat (2) @(negedge clk);
    chk("txd_mid_frame", 64'(txd), 64'h0);
    #2 rst = 1'b0;
    #1;
    chk("txd_async_rst", 64'(txd), 64'h1);
    chk("irq_async_rst", 64'(irq), 64'h0);
    chk("bvalid_async_rst", 64'(bus.bvalid_o), 64'h0);
    tq.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_readies_after_rst", {61'h0, bus.awready_o, bus.wready_o, bus.arready_o}, 64'h7);
    axi_read(32'h4, 64'h0000_0002_0000_0000, 0);
    axi_read(32'h8, 64'h0000_0000_0000_0364, 0);
    repeat (5) @(negedge clk);
    chk("bq_drained", 64'(bq.size()), 64'h0);
    chk("rq_drained", 64'(rq.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
